// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the ALU and its command controller.
package alu_pkg;

  localparam int W = 8;

  localparam logic [3:0] OP_ZERO = 4'b0000;
  localparam logic [3:0] OP_ONE  = 4'b0001;
  localparam logic [3:0] OP_A    = 4'b0010;
  localparam logic [3:0] OP_B    = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_NEG  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_GT   = 4'b1001;
  localparam logic [3:0] OP_LOAD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/custom_alu.sv
// Combinational 8-bit ALU; unassigned opcodes produce zero.
module custom_alu #(
  parameter int W = 8
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z
);
  import alu_pkg::*;

  always_comb begin
    z = '0;
    case (op)
      OP_ZERO: z = '0;
      OP_ONE:  z = W'(1);
      OP_A:    z = a;
      OP_B:    z = b;
      OP_ADD:  z = a + b;
      OP_NEG:  z = '0 - a;
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_EQ:   z = W'(a == b);
      OP_GT:   z = W'(a > b);   // unsigned compare
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/alu_controller.sv
// Command front-end for custom_alu: 4x8 register file, accept/exec/done sequencing.
// Optional ALU_CTRL_FLAGS_EN adds registered zero/negative flags on write-back.
module alu_controller #(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [1:0]   cmd_dst,
  input  logic [1:0]   cmd_srca,
  input  logic [1:0]   cmd_srcb,
  input  logic [W-1:0] cmd_imm,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_dst
`ifdef ALU_CTRL_FLAGS_EN
  ,
  output logic         flag_z,
  output logic         flag_n
`endif
);
  import alu_pkg::*;

  state_t state_q, state_d;

  logic [NREGS-1:0][W-1:0] regs;
  logic [3:0]   alu_op_q;
  logic [W-1:0] alu_a_q, alu_b_q, alu_z;
  logic [W-1:0] imm_q, wb;
  logic [1:0]   dst_q;
  logic         load_q;
  logic         accept;

  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign accept    = cmd_ready && cmd_valid;
  assign wb        = load_q ? imm_q : alu_z;

  custom_alu #(.W(W)) u_alu (
    .op (alu_op_q),
    .a  (alu_a_q),
    .b  (alu_b_q),
    .z  (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are sampled at acceptance, so dst aliasing a source uses the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      imm_q    <= '0;
      dst_q    <= '0;
      load_q   <= 1'b0;
    end else if (accept) begin
      alu_op_q <= (cmd_op == OP_LOAD) ? OP_ZERO : cmd_op;
      alu_a_q  <= regs[cmd_srca];
      alu_b_q  <= regs[cmd_srcb];
      imm_q    <= cmd_imm;
      dst_q    <= cmd_dst;
      load_q   <= (cmd_op == OP_LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      res_data <= '0;
      res_dst  <= '0;
    end else if (state_q == ST_EXEC) begin
      regs[dst_q] <= wb;
      res_data    <= wb;
      res_dst     <= dst_q;
    end
  end

`ifdef ALU_CTRL_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      flag_z <= (wb == '0);
      flag_n <= wb[W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller: vector table plus reset/backpressure sequences.
module tb_alu_controller;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [1:0] cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
  logic [7:0] cmd_imm = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [1:0] res_dst;
`ifdef ALU_CTRL_FLAGS_EN
  logic       flag_z, flag_n;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_controller #(.NREGS(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_srca  (cmd_srca),
    .cmd_srcb  (cmd_srcb),
    .cmd_imm   (cmd_imm),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_dst   (res_dst)
`ifdef ALU_CTRL_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n)
`endif
  );

  typedef struct {
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [7:0] imm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one command with res_ready asserted on the first DONE cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [7:0] imm,
                       output logic [7:0] data, output logic [1:0] rdst, output int lat);
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    data = res_data;
    rdst = res_dst;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] rd;
    int lat;

    vecs[0]  = '{OP_LOAD, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05};
    vecs[1]  = '{OP_LOAD, 2'd2, 2'd0, 2'd0, 8'hFB, 8'hFB};
    vecs[2]  = '{OP_ADD,  2'd3, 2'd1, 2'd2, 8'h00, 8'h00};
    vecs[3]  = '{OP_NEG,  2'd0, 2'd1, 2'd0, 8'h00, 8'hFB};
    vecs[4]  = '{OP_GT,   2'd2, 2'd0, 2'd1, 8'h00, 8'h01};
    vecs[5]  = '{OP_LOAD, 2'd1, 2'd0, 2'd0, 8'h03, 8'h03};
    vecs[6]  = '{OP_ADD,  2'd1, 2'd1, 2'd1, 8'h00, 8'h06};
    vecs[7]  = '{OP_ADD,  2'd1, 2'd1, 2'd1, 8'h00, 8'h0C};
    vecs[8]  = '{OP_LOAD, 2'd2, 2'd0, 2'd0, 8'hAA, 8'hAA};
    vecs[9]  = '{4'b1100, 2'd2, 2'd1, 2'd1, 8'h55, 8'h00};
    vecs[10] = '{OP_A,    2'd2, 2'd2, 2'd0, 8'h00, 8'h00};
    vecs[11] = '{OP_AND,  2'd0, 2'd0, 2'd1, 8'h00, 8'h08};
    vecs[12] = '{OP_OR,   2'd3, 2'd0, 2'd1, 8'h00, 8'h0C};
    vecs[13] = '{OP_EQ,   2'd3, 2'd3, 2'd1, 8'h00, 8'h01};
    vecs[14] = '{OP_ONE,  2'd0, 2'd2, 2'd2, 8'h00, 8'h01};
    vecs[15] = '{OP_B,    2'd0, 2'd0, 2'd1, 8'h00, 8'h0C};
    vecs[16] = '{OP_ZERO, 2'd1, 2'd0, 2'd0, 8'hFF, 8'h00};
    vecs[17] = '{OP_LOAD, 2'd2, 2'd0, 2'd0, 8'hFF, 8'hFF};
    vecs[18] = '{OP_LOAD, 2'd3, 2'd0, 2'd0, 8'h01, 8'h01};
    vecs[19] = '{OP_ADD,  2'd0, 2'd2, 2'd3, 8'h00, 8'h00};
    vecs[20] = '{OP_GT,   2'd0, 2'd3, 2'd2, 8'h00, 8'h00};
    vecs[21] = '{OP_GT,   2'd1, 2'd2, 2'd3, 8'h00, 8'h01};

    #12;
    check("reset_res_valid", res_valid, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_res_data", res_data, 8'h00);
    check("reset_res_dst", res_dst, 0);
`ifdef ALU_CTRL_FLAGS_EN
    check("reset_flag_z", flag_z, 0);
    check("reset_flag_n", flag_n, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      issue(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].imm, d, rd, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp);
      check($sformatf("vec%0d_dst", i), rd, vecs[i].dst);
      check($sformatf("vec%0d_latency", i), lat, 2);
`ifdef ALU_CTRL_FLAGS_EN
      check($sformatf("vec%0d_flag_z", i), flag_z, vecs[i].exp == 8'h00);
      check($sformatf("vec%0d_flag_n", i), flag_n, vecs[i].exp[7]);
`endif
    end

    // Backpressure: hold the result 5 cycles while a competing command pulses.
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_dst = 2'd0; cmd_imm = 8'h5A;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_res_valid", res_valid, 1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_dst = 2'd3; cmd_imm = 8'h77;
      end else begin
        cmd_valid = 1'b0;
      end
      check($sformatf("bp_cmd_ready_c%0d", c), cmd_ready, 0);
      check($sformatf("bp_res_data_c%0d", c), res_data, 8'h5A);
      check($sformatf("bp_res_valid_c%0d", c), res_valid, 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_cmd_ready_after", cmd_ready, 1);
    check("bp_res_valid_after", res_valid, 0);
    issue(OP_A, 2'd3, 2'd3, 2'd0, 8'h00, d, rd, lat);
    check("bp_r3_untouched", d, 8'h01);

    // Reset during EXEC discards the pending write.
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_dst = 2'd1; cmd_imm = 8'hEE;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_exec_res_valid", res_valid, 0);
    check("rst_exec_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    check("rst_exec_res_valid_held", res_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      issue(OP_A, r[1:0], r[1:0], 2'd0, 8'h00, d, rd, lat);
      check($sformatf("rst_r%0d_zero", r), d, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
